// File: rtl/cpu8_pkg.sv
// Shared types and widths for the 8-bit processor front end.
package cpu8_pkg;

    localparam int unsigned PC_W    = 8;
    localparam int unsigned INSTR_W = 8;

    typedef enum logic [0:0] {RUN, HALTED} fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-to-decode handshake: buffered instruction, its address, valid/ready.
interface instruction_fetch_unit_if;
    import cpu8_pkg::*;

    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    instr_out_pc;
    logic               instr_out_valid;
    logic               instr_out_ready;

    modport master (
        output instr_out,
        output instr_out_pc,
        output instr_out_valid,
        input  instr_out_ready
    );

    modport slave (
        input  instr_out,
        input  instr_out_pc,
        input  instr_out_valid,
        output instr_out_ready
    );

endinterface

// File: rtl/fetch_skid_buffer.sv
// Two-entry FIFO of fetched {pc, instr} pairs; head is always entry 0.
module fetch_skid_buffer
    import cpu8_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   occ
);

    fetch_entry_t head_q;
    fetch_entry_t tail_q;
    logic [1:0]   occ_q;
    logic [1:0]   occ_after;
    logic         do_pop;
    logic         do_push;

    always_comb begin
        do_pop    = pop && (occ_q != 2'd0);
        occ_after = occ_q - {1'b0, do_pop};
        do_push   = push && (occ_after != 2'd2);
    end

    // On a simultaneous pop and push into an emptied head, the push write wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else if (flush) begin
            occ_q <= 2'd0;
        end else begin
            if (do_pop) begin
                head_q <= tail_q;
            end
            if (do_push) begin
                if (occ_after == 2'd0) begin
                    head_q <= push_entry;
                end else begin
                    tail_q <= push_entry;
                end
            end
            occ_q <= occ_after + {1'b0, do_push};
        end
    end

    assign head = head_q;
    assign occ  = occ_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, 1-cycle memory tracking, skid buffer, redirect and halt control.
// Optional return-address stack enabled by FETCH_CALL_STACK_EN.
module instruction_fetch_unit
    import cpu8_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC    = 8'h00,
    parameter int unsigned     STACK_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic [PC_W-1:0]          pccounter,
    input  logic [INSTR_W-1:0]       saidaInstrucao,
    instruction_fetch_unit_if.master dec,
    input  logic                     branch_taken,
    input  logic [PC_W-1:0]          branch_target,
    input  logic                     halt,
    input  logic                     resume,
    output logic                     halted,
    input  logic                     call_req,
    input  logic                     ret_req,
    input  logic [PC_W-1:0]          ret_addr,
    output logic                     stack_err
);

    fetch_state_t    state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] inflight_pc_q;
    logic            inflight_q;
    logic            halted_q;

    logic            redirect;
    logic [PC_W-1:0] target;
    logic            pop;
    logic            issue;
    logic [2:0]      load;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic [1:0]      occ;

`ifdef FETCH_CALL_STACK_EN
    localparam int unsigned CntW = $clog2(STACK_DEPTH + 1);

    logic [PC_W-1:0] stack_q [STACK_DEPTH];
    logic [CntW-1:0] depth_q;
    logic            err_q;
    logic            do_ret;
    logic            stack_full;
    logic            stack_empty;

    // A branch in the same cycle as a return takes the branch target and leaves the stack.
    always_comb begin
        do_ret      = ret_req && !call_req && !branch_taken;
        stack_full  = (depth_q == CntW'(STACK_DEPTH));
        stack_empty = (depth_q == '0);
        redirect    = branch_taken || call_req || ret_req;
        target      = branch_target;
        if (do_ret) begin
            target = stack_empty ? RESET_PC : stack_q[0];
        end
    end

    // Entry 0 is the top; a push when full shifts the oldest entry out.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(STACK_DEPTH); i++) begin
                stack_q[i] <= '0;
            end
            depth_q <= '0;
            err_q   <= 1'b0;
        end else if (call_req) begin
            for (int i = int'(STACK_DEPTH) - 1; i > 0; i--) begin
                stack_q[i] <= stack_q[i-1];
            end
            stack_q[0] <= ret_addr;
            if (stack_full) begin
                err_q <= 1'b1;
            end else begin
                depth_q <= depth_q + CntW'(1);
            end
        end else if (do_ret) begin
            if (stack_empty) begin
                err_q <= 1'b1;
            end else begin
                for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
                    stack_q[i] <= stack_q[i+1];
                end
                depth_q <= depth_q - CntW'(1);
            end
        end
    end

    assign stack_err = err_q;
`else
    localparam int unsigned unused_stack_depth = STACK_DEPTH;
    logic unused_stack_ports;

    always_comb begin
        redirect = branch_taken;
        target   = branch_target;
    end

    assign unused_stack_ports = ^{call_req, ret_req, ret_addr};
    assign stack_err          = 1'b0;
`endif

    // Issue only if the entry it produces will find room after this cycle's pop.
    always_comb begin
        pop   = (occ != 2'd0) && dec.instr_out_ready;
        load  = {1'b0, occ} + {2'b0, inflight_q};
        issue = (state_q == RUN) && !halt && !redirect && (load <= (3'd1 + {2'b0, pop}));
    end

    assign push_entry = '{pc: inflight_pc_q, instr: saidaInstrucao};

    fetch_skid_buffer u_skid (
        .clock      (clock),
        .reset      (reset),
        .push       (inflight_q && !redirect),
        .push_entry (push_entry),
        .pop        (pop && !redirect),
        .flush      (redirect),
        .head       (head),
        .occ        (occ)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            halted_q      <= 1'b0;
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            if (redirect) begin
                pc_q <= target;
            end else if (issue) begin
                pc_q <= pc_q + PC_W'(1);
            end
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= pc_q;
            end
            case (state_q)
                RUN: begin
                    if (halt) begin
                        state_q  <= HALTED;
                        halted_q <= 1'b1;
                    end
                end
                HALTED: begin
                    if (resume && !halt) begin
                        state_q  <= RUN;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    assign pccounter           = pc_q;
    assign halted              = halted_q;
    assign dec.instr_out       = head.instr;
    assign dec.instr_out_pc    = head.pc;
    assign dec.instr_out_valid = (occ != 2'd0);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a queue-based reference model.
module tb_instruction_fetch_unit;

    localparam logic [7:0] RESET_PC    = 8'h00;
    localparam int         STACK_DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] pccounter;
    logic [7:0] saidaInstrucao = 8'h00;
    logic       ready = 1'b1;
    logic       branch_taken = 1'b0;
    logic [7:0] branch_target = 8'h00;
    logic       halt = 1'b0;
    logic       resume = 1'b0;
    logic       halted;
    logic       call_req = 1'b0;
    logic       ret_req = 1'b0;
    logic [7:0] ret_addr = 8'h00;
    logic       stack_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    instruction_fetch_unit_if dec_if ();
    assign dec_if.instr_out_ready = ready;

    instruction_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .pccounter      (pccounter),
        .saidaInstrucao (saidaInstrucao),
        .dec            (dec_if),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .halt           (halt),
        .resume         (resume),
        .halted         (halted),
        .call_req       (call_req),
        .ret_req        (ret_req),
        .ret_addr       (ret_addr),
        .stack_err      (stack_err)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] memf(input logic [7:0] a);
        return (a ^ 8'h5A) + 8'd3;
    endfunction

    // Synchronous instruction memory: data for last cycle's address.
    always @(posedge clock) saidaInstrucao <= memf(pccounter);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pcs awaiting delivery, at most one fetch in flight.
    logic [7:0] m_pc = RESET_PC;
    logic [7:0] m_fly_pc = 8'h00;
    bit         m_fly = 1'b0;
    bit         m_halted = 1'b0;
    bit         m_err = 1'b0;
    logic [7:0] m_q[$];
    logic [7:0] m_stk[$];

    task automatic model_step();
        bit         pop;
        bit         redir;
        bit         iss;
        logic [7:0] tgt;
        int         load;
        if (reset) begin
            m_pc = RESET_PC; m_fly = 1'b0; m_halted = 1'b0; m_err = 1'b0;
            m_q.delete(); m_stk.delete();
            return;
        end
        pop   = (m_q.size() > 0) && ready;
        redir = branch_taken;
        tgt   = branch_target;
`ifdef FETCH_CALL_STACK_EN
        if (call_req) begin
            redir = 1'b1;
            if (m_stk.size() == STACK_DEPTH) begin
                void'(m_stk.pop_back());
                m_err = 1'b1;
            end
            m_stk.push_front(ret_addr);
        end else if (ret_req && !branch_taken) begin
            redir = 1'b1;
            if (m_stk.size() == 0) begin
                tgt   = RESET_PC;
                m_err = 1'b1;
            end else begin
                tgt = m_stk.pop_front();
            end
        end else if (ret_req) begin
            redir = 1'b1;
        end
`endif
        if (redir) begin
            m_q.delete();
            m_fly = 1'b0;
            m_pc  = tgt;
        end else begin
            load = m_q.size() + int'(m_fly) - int'(pop);
            iss  = !m_halted && !halt && (load <= 1);
            if (pop) void'(m_q.pop_front());
            if (m_fly) m_q.push_back(m_fly_pc);
            m_fly = iss;
            if (iss) begin
                m_fly_pc = m_pc;
                m_pc     = m_pc + 8'd1;
            end
        end
        if (!m_halted && halt) m_halted = 1'b1;
        else if (m_halted && resume && !halt) m_halted = 1'b0;
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (!reset) begin
            chk("m_pccounter", pccounter, m_pc);
            chk("m_valid", dec_if.instr_out_valid, m_q.size() > 0);
            if (m_q.size() > 0) begin
                chk("m_head_pc", dec_if.instr_out_pc, m_q[0]);
                chk("m_head_instr", dec_if.instr_out, memf(m_q[0]));
            end
            chk("m_halted", halted, m_halted);
            chk("m_stack_err", stack_err, m_err);
        end
    end

    task automatic go(input int n);
        while (cyc < n) begin
            @(negedge clock);
            cyc++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; ready = 1'b1; branch_taken = 1'b0; halt = 1'b0; resume = 1'b0;
        call_req = 1'b0; ret_req = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_pc", pccounter, RESET_PC);
        chk("rst_valid", dec_if.instr_out_valid, 1'b0);
        chk("rst_instr", dec_if.instr_out, 8'h00);
        chk("rst_instr_pc", dec_if.instr_out_pc, 8'h00);
        chk("rst_halted", halted, 1'b0);
        chk("rst_stack_err", stack_err, 1'b0);
        reset = 1'b0;
        cyc   = 0;
    endtask

    initial begin
        // Streaming, then 3 cycles of backpressure with head 05.
        do_reset();
        go(1);  chk("t1_pc1", pccounter, 8'h01); chk("t1_v1", dec_if.instr_out_valid, 1'b0);
        go(2);  chk("t1_pc2", pccounter, 8'h02); chk("t1_v2", dec_if.instr_out_valid, 1'b1);
        chk("t1_out0", dec_if.instr_out_pc, 8'h00); chk("t1_instr0", dec_if.instr_out, 8'h5D);
        go(3);  chk("t1_out1", dec_if.instr_out_pc, 8'h01);
        go(4);  chk("t1_out2", dec_if.instr_out_pc, 8'h02); chk("t1_pc4", pccounter, 8'h04);
        go(7);  chk("t2_head", dec_if.instr_out_pc, 8'h05); ready = 1'b0;
        go(8);  chk("t2_hold8", dec_if.instr_out_pc, 8'h05); chk("t2_pc8", pccounter, 8'h07);
        go(10); chk("t2_hold10", dec_if.instr_out_pc, 8'h05); chk("t2_pc10", pccounter, 8'h07);
        ready = 1'b1;
        go(11); chk("t2_out06", dec_if.instr_out_pc, 8'h06);
        go(12); chk("t2_out07", dec_if.instr_out_pc, 8'h07);
        go(13); chk("t2_out08", dec_if.instr_out_pc, 8'h08);

        // Branch to 10 while head is 03.
        do_reset();
        go(5);  chk("t3_head", dec_if.instr_out_pc, 8'h03);
        branch_taken = 1'b1; branch_target = 8'h10;
        go(6);  branch_taken = 1'b0;
        chk("t3_v6", dec_if.instr_out_valid, 1'b0); chk("t3_pc6", pccounter, 8'h10);
        go(7);  chk("t3_v7", dec_if.instr_out_valid, 1'b0);
        go(8);  chk("t3_out10", dec_if.instr_out_pc, 8'h10);
        go(9);  chk("t3_out11", dec_if.instr_out_pc, 8'h11);

        // Wrap through FF.
        do_reset();
        go(2);  branch_taken = 1'b1; branch_target = 8'hFE;
        go(3);  branch_taken = 1'b0; chk("t4_pc", pccounter, 8'hFE);
        go(5);  chk("t4_outFE", dec_if.instr_out_pc, 8'hFE);
        go(6);  chk("t4_outFF", dec_if.instr_out_pc, 8'hFF);
        go(7);  chk("t4_out00", dec_if.instr_out_pc, 8'h00);
        go(8);  chk("t4_out01", dec_if.instr_out_pc, 8'h01);

        // Halt at 09 (with resume also high), redirect while halted, resume.
        do_reset();
        go(9);  halt = 1'b1; resume = 1'b1;
        go(10); halt = 1'b0; resume = 1'b0;
        chk("t5_halted", halted, 1'b1); chk("t5_pc10", pccounter, 8'h09);
        chk("t5_drain", dec_if.instr_out_pc, 8'h08);
        go(11); chk("t5_empty", dec_if.instr_out_valid, 1'b0);
        go(13); chk("t5_frozen", pccounter, 8'h09); resume = 1'b1;
        go(14); resume = 1'b0; chk("t5_run", halted, 1'b0); chk("t5_pc14", pccounter, 8'h09);
        go(16); chk("t5_out09", dec_if.instr_out_pc, 8'h09);
        go(18); halt = 1'b1; branch_taken = 1'b1; branch_target = 8'h40;
        go(19); halt = 1'b0; branch_taken = 1'b0;
        chk("t5_hb_halted", halted, 1'b1); chk("t5_hb_pc", pccounter, 8'h40);
        go(20); branch_taken = 1'b1; branch_target = 8'h50;
        go(21); branch_taken = 1'b0;
        chk("t5_hr_pc", pccounter, 8'h50); chk("t5_hr_halted", halted, 1'b1);
        resume = 1'b1;
        go(22); resume = 1'b0; chk("t5_res_pc", pccounter, 8'h50);
        go(24); chk("t5_out50", dec_if.instr_out_pc, 8'h50);

        // Asynchronous reset between edges with the buffer full.
        do_reset();
        ready = 1'b0;
        go(4);  chk("t6_full", dec_if.instr_out_pc, 8'h00); chk("t6_pc", pccounter, 8'h02);
        #2 reset = 1'b1;
        #1;
        chk("t6_async_valid", dec_if.instr_out_valid, 1'b0);
        chk("t6_async_pc", pccounter, RESET_PC);
        chk("t6_async_instr", dec_if.instr_out, 8'h00);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0; ready = 1'b1; cyc = 0;
        go(3);  chk("t6_after", dec_if.instr_out_pc, 8'h01);

`ifdef FETCH_CALL_STACK_EN
        do_reset();
        go(3);  call_req = 1'b1; branch_target = 8'h20; ret_addr = 8'h31;
        go(4);  call_req = 1'b0; chk("t7_call_pc", pccounter, 8'h20);
        go(6);  chk("t7_out20", dec_if.instr_out_pc, 8'h20);
        go(8);  ret_req = 1'b1;
        go(9);  ret_req = 1'b0; chk("t7_ret_pc", pccounter, 8'h31);
        go(11); chk("t7_out31", dec_if.instr_out_pc, 8'h31); ret_req = 1'b1;
        go(12); ret_req = 1'b0;
        chk("t7_uf_pc", pccounter, RESET_PC); chk("t7_uf_err", stack_err, 1'b1);
        go(14);
`endif

        go(cyc + 2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
